spi_regif: RTL and testbench
============================

// Module: spi_regif
// PURPOSE
//  SPI-slave register interface; host side of the motor control register file.
//  Decodes SPI mode-0 frames from the host MCU into wrtdata plus one-clock load strobes
//  (cfgld0..2, ctrlld, wdogdivld, wdreset), and returns controlrdata/hwconfig on miso.
//  Sits between the board SPI pins and the control block; all outputs are in the clk domain.
// PARAMETERS
//  ADDR_CFG0     7'h00  config register 0 (write-only)
//  ADDR_CFG1     7'h01  config register 1 (write-only)
//  ADDR_CFG2     7'h02  config register 2 (write-only)
//  ADDR_CTRL     7'h03  control register (write -> ctrlld, read -> controlrdata)
//  ADDR_WDOGDIV  7'h04  watchdog divisor (write-only)
//  ADDR_WDRESET  7'h05  any write pulses wdreset; data ignored
//  ADDR_HWCFG    7'h06  read-only, returns hwconfig
// PORTS
//  clk           in   1  system clock; must be >= 8x sck frequency
//  rstn          in   1  asynchronous, active-low reset
//  sck           in   1  SPI clock, async to clk, idles low
//  csn           in   1  SPI chip select, active low, async to clk
//  mosi          in   1  SPI data in, MSB first
//  miso          out  1  SPI data out, MSB first
//  misooe        out  1  miso output enable (high while frame active)
//  controlrdata  in   8  control register readback
//  hwconfig      in   8  hardware configuration readback
//  wrtdata       out  8  write data; valid with every strobe, held until next write
//  cfgld0/1/2    out  1  one-clk load strobe, config registers 0/1/2
//  ctrlld        out  1  one-clk load strobe, control register
//  wdogdivld     out  1  one-clk load strobe, watchdog divisor
//  wdreset       out  1  one-clk watchdog restart pulse
// BEHAVIOUR
//  Reset: all strobes 0, wrtdata 8'h00, miso 0, misooe 0, state IDLE, armed=0.
//  Input sync: sck, csn, mosi each pass a 2-FF synchroniser; sck edges from sync'd history.
//  Frame: csn low; byte 0 = {rw, addr[6:0]} (rw=1 read); bytes 1..n = data.
//  Burst: address increments after each data byte; 7'h7F wraps to 7'h00.
//  FSM: IDLE -> CMD on sync'd csn fall (only if armed); CMD -> DATA after 8th rising edge;
//   DATA -> DATA per byte; any state -> IDLE on sync'd csn high.
//  Sampling: mosi sampled at sync'd sck rising edge; 3-bit bit counter, wraps 7->0.
//  Write: on 8th data bit, decoded strobe asserts exactly 1 clk, 4 clk after the raw sck
//   rising edge (2 sync + edge detect + output reg); wrtdata updates same cycle.
//  Writes to ADDR_HWCFG or unmapped addresses: no strobe, wrtdata unchanged.
//  Read: readback latched at end of CMD byte (and at end of each DATA byte in a burst for
//   addr+1); MSB driven on miso at latch; shift on each sync'd sck falling edge.
//   ADDR_CTRL -> controlrdata, ADDR_HWCFG -> hwconfig, all others -> 8'h00.
//   Read frames never assert strobes; mosi ignored in read data bytes.
//  misooe = 1 in CMD/DATA, 0 in IDLE; miso = 0 whenever misooe = 0.
//  Abort: csn high with bit counter != 0 discards the partial byte, no strobe.
//  csn rise in same clk as 8th-bit edge: the completed byte is honoured (edge processed first).
//  Reset release with csn low: armed stays 0 until csn seen high; that frame is ignored.
//  Never more than one strobe high in any clk cycle.
// STRUCTURE
//  Package bdc_regmap_pkg: address localparams above, FSM state encoding, rw bit index.
//  Sub-module spi_sync2 (2-FF synchroniser with async active-low reset, reset value
//   parameter: 1 for csn, 0 for sck/mosi); instantiated three times.
//  Top holds FSM, bit counter, shift registers, address register, decode, readback mux.
// TESTING
//  Write 0x01,0x2D -> cfgld1 high 1 clk, wrtdata=8'h2D; no other strobe.
//  Write 0x03 burst 0x08,0x11 -> ctrlld w/ 8'h08 then wdogdivld w/ 8'h11 (addr incr).
//  Read 0x86 with hwconfig=8'h30 -> miso shifts 0011_0000; zero strobes; misooe low after csn.
//  Write 0x05,0xFF then csn high after 4 data bits -> wdreset once? no: abort -> no wdreset.
//  Reset asserted mid-frame, released with csn low -> frame ignored; next frame works.
//  Read 0x83 then 0x84 burst, controlrdata=8'hC9 -> 1100_1001 then 0000_0000.

Source files
------------

// File: rtl/bdc_regmap_pkg.sv
// Register map, FSM encoding and readback mux shared by the SPI register interface.
package bdc_regmap_pkg;

    localparam logic [6:0] ADDR_CFG0    = 7'h00;
    localparam logic [6:0] ADDR_CFG1    = 7'h01;
    localparam logic [6:0] ADDR_CFG2    = 7'h02;
    localparam logic [6:0] ADDR_CTRL    = 7'h03;
    localparam logic [6:0] ADDR_WDOGDIV = 7'h04;
    localparam logic [6:0] ADDR_WDRESET = 7'h05;
    localparam logic [6:0] ADDR_HWCFG   = 7'h06;

    localparam int RW_BIT  = 7;
    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_CMD  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DATA = 2'd2;

    function automatic logic [7:0] rd_mux(input logic [6:0] addr,
                                          input logic [7:0] ctrl,
                                          input logic [7:0] hw);
        case (addr)
            ADDR_CTRL:  rd_mux = ctrl;
            ADDR_HWCFG: rd_mux = hw;
            default:    rd_mux = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_regif_if.sv
// Pin and register-side bundle of the SPI register interface; slave is the DUT view.
interface spi_regif_if;
    import bdc_regmap_pkg::*;

    // No valid/ready pair here: each load strobe is a one-cycle qualifier for wrtdata,
    // and misooe qualifies miso (miso is 0 whenever misooe is 0).
    logic               sck;
    logic               csn;
    logic               mosi;
    logic               miso;
    logic               misooe;
    logic [7:0]         controlrdata;
    logic [7:0]         hwconfig;
    logic [7:0]         wrtdata;
    logic               cfgld0;
    logic               cfgld1;
    logic               cfgld2;
    logic               ctrlld;
    logic               wdogdivld;
    logic               wdreset;
    logic [STATE_W-1:0] dbg_state;

    modport slave (
        input  sck, csn, mosi, controlrdata, hwconfig,
        output miso, misooe, wrtdata, cfgld0, cfgld1, cfgld2, ctrlld, wdogdivld, wdreset,
        output dbg_state
    );

    modport master (
        output sck, csn, mosi, controlrdata, hwconfig,
        input  miso, misooe, wrtdata, cfgld0, cfgld1, cfgld2, ctrlld, wdogdivld, wdreset,
        input  dbg_state
    );

endinterface

// File: rtl/spi_sync2.sv
// Two-flop synchroniser with a selectable reset value.
module spi_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave decoding host frames into register load strobes and readback on miso.
module spi_regif
    import bdc_regmap_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    spi_regif_if.slave  bus
);

    logic sck_s, csn_s, mosi_s;

    spi_sync2 #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rstn(rstn), .d(bus.sck),  .q(sck_s));
    spi_sync2 #(.RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .rstn(rstn), .d(bus.csn),  .q(csn_s));
    spi_sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rstn(rstn), .d(bus.mosi), .q(mosi_s));

    // Edge detect is registered; csn and mosi ride the same stage so they stay aligned.
    logic sck_d, rise_q, fall_q, mosi_q, csn_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_d  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            mosi_q <= 1'b0;
            csn_q  <= 1'b1;
        end else begin
            sck_d  <= sck_s;
            rise_q <= sck_s & ~sck_d;
            fall_q <= ~sck_s & sck_d;
            mosi_q <= mosi_s;
            csn_q  <= csn_s;
        end
    end

    logic [1:0]         settle;
    logic               armed;
    logic [STATE_W-1:0] state;
    logic [2:0]         bitcnt;
    logic [6:0]         sh_in;
    logic [6:0]         addr;
    logic               rw;
    logic [7:0]         rd_sh;
    logic [7:0]         rx_byte;
    logic               byte_done;

    assign rx_byte   = {sh_in, mosi_q};
    assign byte_done = rise_q && (bitcnt == 3'd7);

    // csn_q shows its reset value for the first cycles; arming waits for the real pin level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle <= 2'd0;
            armed  <= 1'b0;
            state  <= ST_IDLE;
            bitcnt <= 3'd0;
            sh_in  <= 7'd0;
            addr   <= 7'd0;
            rw     <= 1'b0;
            rd_sh  <= 8'h00;
        end else begin
            if (settle != 2'd3) settle <= settle + 2'd1;
            else if (csn_q)     armed  <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!csn_q && armed) begin
                        state  <= ST_CMD;
                        bitcnt <= 3'd0;
                        rd_sh  <= 8'h00;
                    end
                end
                default: begin
                    if (rise_q) begin
                        bitcnt <= bitcnt + 3'd1;
                        sh_in  <= rx_byte[6:0];
                        if (byte_done && state == ST_CMD) begin
                            rw    <= rx_byte[RW_BIT];
                            addr  <= rx_byte[6:0];
                            state <= ST_DATA;
                            rd_sh <= rx_byte[RW_BIT] ?
                                     rd_mux(rx_byte[6:0], bus.controlrdata, bus.hwconfig) : 8'h00;
                        end else if (byte_done) begin
                            addr  <= addr + 7'd1;
                            rd_sh <= rw ? rd_mux(addr + 7'd1, bus.controlrdata, bus.hwconfig)
                                        : 8'h00;
                        end
                    end else if (fall_q && bitcnt != 3'd0) begin
                        // The fall right after a reload is skipped so the MSB meets the next rise.
                        rd_sh <= {rd_sh[6:0], 1'b0};
                    end
                    if (csn_q) begin
                        state  <= ST_IDLE;
                        bitcnt <= 3'd0;
                    end
                end
            endcase
        end
    end

    logic [5:0] wr_hit;
    logic [5:0] stb_q;
    logic [7:0] wrtdata_q;

    always_comb begin
        wr_hit = 6'd0;
        if (state == ST_DATA && byte_done && !rw) begin
            case (addr)
                ADDR_CFG0:    wr_hit[0] = 1'b1;
                ADDR_CFG1:    wr_hit[1] = 1'b1;
                ADDR_CFG2:    wr_hit[2] = 1'b1;
                ADDR_CTRL:    wr_hit[3] = 1'b1;
                ADDR_WDOGDIV: wr_hit[4] = 1'b1;
                ADDR_WDRESET: wr_hit[5] = 1'b1;
                default:      wr_hit    = 6'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stb_q     <= 6'd0;
            wrtdata_q <= 8'h00;
        end else begin
            stb_q <= wr_hit;
            if (wr_hit != 6'd0) wrtdata_q <= rx_byte;
        end
    end

    assign bus.cfgld0    = stb_q[0];
    assign bus.cfgld1    = stb_q[1];
    assign bus.cfgld2    = stb_q[2];
    assign bus.ctrlld    = stb_q[3];
    assign bus.wdogdivld = stb_q[4];
    assign bus.wdreset   = stb_q[5];
    assign bus.wrtdata   = wrtdata_q;
    assign bus.misooe    = (state != ST_IDLE);
    assign bus.miso      = bus.misooe & rd_sh[7];
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_spi_regif.sv
// Bench for spi_regif: SPI master tasks, register-map model, per-cycle output compare.
module tb_spi_regif;
    import bdc_regmap_pkg::*;

    localparam int HALF = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    spi_regif_if bus();
    spi_regif dut (.clk(clk), .rstn(rstn), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic started  = 1'b0;

    int         exp_stb_at[int];
    logic [7:0] exp_wd_at[int];
    logic       oe_ev[int];
    logic [7:0] model_wd    = 8'h00;
    logic       exp_oe      = 1'b0;
    logic       model_armed = 1'b0;
    logic       active      = 1'b0;
    logic [7:0] ctrl_v      = 8'h00;
    logic [7:0] hw_v        = 8'h00;
    logic [7:0] tx_data[8];
    logic [7:0] rx_data[8];
    logic [7:0] exp_q[$];
    int         pulse_cnt[6];
    int         snap[6];
    logic [5:0] act_stb, exp_stb;

    assign bus.controlrdata = ctrl_v;
    assign bus.hwconfig     = hw_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [7:0] rd_model(input logic [6:0] a);
        if (a == ADDR_CTRL)  return ctrl_v;
        if (a == ADDR_HWCFG) return hw_v;
        return 8'h00;
    endfunction

    // Per-cycle scoreboard against the scheduled strobe/misooe events.
    always @(posedge clk) begin
        #1;
        if (rstn && started) begin
            exp_stb = exp_stb_at.exists(cyc) ? 6'(exp_stb_at[cyc]) : 6'd0;
            if (exp_wd_at.exists(cyc)) model_wd = exp_wd_at[cyc];
            if (oe_ev.exists(cyc))     exp_oe   = oe_ev[cyc];
            act_stb = {bus.wdreset, bus.wdogdivld, bus.ctrlld, bus.cfgld2, bus.cfgld1, bus.cfgld0};
            chk("strobes", 32'(act_stb), 32'(exp_stb));
            chk("wrtdata", 32'(bus.wrtdata), 32'(model_wd));
            chk("misooe", 32'(bus.misooe), 32'(exp_oe));
            if (!bus.misooe) chk("miso_idle", 32'(bus.miso), 32'd0);
            for (int i = 0; i < 6; i++) if (act_stb[i]) pulse_cnt[i]++;
        end
    end

    task automatic snapshot();
        for (int i = 0; i < 6; i++) snap[i] = pulse_cnt[i];
    endtask

    function automatic int dlt(input int i);
        return pulse_cnt[i] - snap[i];
    endfunction

    function automatic int dtot();
        int s = 0;
        for (int i = 0; i < 6; i++) s += pulse_cnt[i] - snap[i];
        return s;
    endfunction

    task automatic reset_dut();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("reset_strobes", 32'({bus.wdreset, bus.wdogdivld, bus.ctrlld, bus.cfgld2,
                                  bus.cfgld1, bus.cfgld0}), 32'd0);
        chk("reset_wrtdata", 32'(bus.wrtdata), 32'h00);
        chk("reset_misooe", 32'(bus.misooe), 32'd0);
        chk("reset_miso", 32'(bus.miso), 32'd0);
        chk("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        exp_stb_at.delete();
        exp_wd_at.delete();
        oe_ev.delete();
        model_wd = 8'h00;
        exp_oe   = 1'b0;
        active   = 1'b0;
        repeat (3) @(negedge clk);
        rstn        = 1'b1;
        started     = 1'b1;
        model_armed = bus.csn;
        repeat (10) @(negedge clk);
    endtask

    task automatic csn_low();
        @(negedge clk);
        bus.csn = 1'b0;
        active  = model_armed;
        if (active) oe_ev[cyc + 4] = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic csn_high();
        repeat (4) @(negedge clk);
        bus.csn        = 1'b1;
        oe_ev[cyc + 4] = 1'b0;
        model_armed    = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Shifts nbits MSB first; miso is sampled just before each rising sck edge.
    task automatic xfer_bits(input logic [7:0] tx, input int nbits, input logic [5:0] mask,
                             input logic end_csn, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            bus.mosi = tx[7-b];
            repeat (HALF - 1) @(negedge clk);
            rx      = {rx[6:0], bus.miso};
            bus.sck = 1'b1;
            if (b == 7 && mask != 6'd0) begin
                exp_stb_at[cyc + 4] = int'(mask);
                exp_wd_at[cyc + 4]  = tx;
            end
            if (b == nbits - 1 && end_csn) begin
                bus.csn        = 1'b1;
                oe_ev[cyc + 4] = 1'b0;
                model_armed    = 1'b1;
            end
            repeat (HALF) @(negedge clk);
            bus.sck = 1'b0;
        end
    endtask

    task automatic frame(input logic rw, input logic [6:0] addr, input int n,
                         input int abort_bits, input logic fast_end);
        logic [7:0] rx;
        logic [6:0] a;
        logic [5:0] mask;
        logic [7:0] e;
        csn_low();
        xfer_bits({rw, addr}, 8, 6'd0, 1'b0, rx);
        for (int i = 0; i < n; i++) begin
            a    = addr + 7'(i);
            mask = (active && !rw && a <= 7'd5) ? (6'd1 << a) : 6'd0;
            if (rw) exp_q.push_back(active ? rd_model(a) : 8'h00);
            xfer_bits(tx_data[i], 8, mask, fast_end && (i == n - 1) && abort_bits == 0, rx);
            rx_data[i] = rx;
            if (rw) begin
                e = exp_q.pop_front();
                chk("read_byte", 32'(rx), 32'(e));
            end
        end
        if (abort_bits > 0) xfer_bits(tx_data[n], abort_bits, 6'd0, 1'b0, rx);
        if (fast_end && abort_bits == 0 && n > 0) repeat (12) @(negedge clk);
        else csn_high();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        bus.sck  = 1'b0;
        bus.csn  = 1'b1;
        bus.mosi = 1'b0;
        for (int i = 0; i < 6; i++) pulse_cnt[i] = 0;
        reset_dut();

        snapshot();
        tx_data[0] = 8'h2D;
        frame(1'b0, 7'h01, 1, 0, 1'b0);
        chk("lit_cfg1_pulse", 32'(dlt(1)), 32'd1);
        chk("lit_cfg1_total", 32'(dtot()), 32'd1);
        chk("lit_cfg1_data", 32'(bus.wrtdata), 32'h2D);

        snapshot();
        tx_data[0] = 8'h08;
        tx_data[1] = 8'h11;
        frame(1'b0, 7'h03, 2, 0, 1'b0);
        chk("lit_burst_ctrl", 32'(dlt(3)), 32'd1);
        chk("lit_burst_wdog", 32'(dlt(4)), 32'd1);
        chk("lit_burst_total", 32'(dtot()), 32'd2);
        chk("lit_burst_data", 32'(bus.wrtdata), 32'h11);

        snapshot();
        hw_v       = 8'h30;
        tx_data[0] = 8'hA5;
        frame(1'b1, 7'h06, 1, 0, 1'b0);
        chk("lit_hwcfg_read", 32'(rx_data[0]), 32'h30);
        chk("lit_read_nostb", 32'(dtot()), 32'd0);
        chk("lit_oe_after", 32'(bus.misooe), 32'd0);

        snapshot();
        tx_data[0] = 8'hFF;
        frame(1'b0, 7'h05, 0, 4, 1'b0);
        chk("lit_abort_wdr", 32'(dlt(5)), 32'd0);

        snapshot();
        csn_low();
        xfer_bits(8'h05, 8, 6'd0, 1'b0, rx);
        xfer_bits(8'hFF, 4, 6'd0, 1'b0, rx);
        reset_dut();
        xfer_bits(8'h05, 8, 6'd0, 1'b0, rx);
        xfer_bits(8'hFF, 8, 6'd0, 1'b0, rx);
        csn_high();
        chk("lit_rst_ignored", 32'(dtot()), 32'd0);
        tx_data[0] = 8'h00;
        frame(1'b0, 7'h05, 1, 0, 1'b0);
        chk("lit_rst_next_wdr", 32'(dlt(5)), 32'd1);

        ctrl_v     = 8'hC9;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'hFF;
        frame(1'b1, 7'h03, 2, 0, 1'b0);
        chk("lit_ctrl_read0", 32'(rx_data[0]), 32'hC9);
        chk("lit_ctrl_read1", 32'(rx_data[1]), 32'h00);

        snapshot();
        tx_data[0] = 8'hAA;
        tx_data[1] = 8'h55;
        frame(1'b0, 7'h7F, 2, 0, 1'b0);
        chk("lit_wrap_cfg0", 32'(dlt(0)), 32'd1);
        chk("lit_wrap_data", 32'(bus.wrtdata), 32'h55);

        snapshot();
        tx_data[0] = 8'h5A;
        frame(1'b0, 7'h02, 1, 0, 1'b1);
        chk("lit_fast_cfg2", 32'(dlt(2)), 32'd1);
        chk("lit_fast_data", 32'(bus.wrtdata), 32'h5A);

        snapshot();
        tx_data[0] = 8'h77;
        frame(1'b0, 7'h06, 1, 0, 1'b0);
        chk("lit_hwcfg_nowr", 32'(dtot()), 32'd0);
        chk("lit_hwcfg_hold", 32'(bus.wrtdata), 32'h5A);

        for (int k = 0; k < 30; k++) begin
            int         sel, n, ab, r;
            logic       rw, fe;
            logic [6:0] addr;
            ctrl_v = 8'($urandom);
            hw_v   = 8'($urandom);
            for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
            sel  = $urandom_range(0, 9);
            addr = (sel <= 6) ? 7'(sel) : (sel == 7) ? 7'h7F : (sel == 8) ? 7'h7E : 7'($urandom);
            rw   = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, 3);
            r    = $urandom_range(0, 5);
            ab   = (r == 0) ? $urandom_range(1, 7) : 0;
            fe   = (r == 1);
            frame(rw, addr, n, ab, fe);
        end

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
